// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared types and constants for the PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ISR  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_INT  = 3'd0,
        SRC_ERET = 3'd1,
        SRC_JUMP = 3'd2,
        SRC_BR   = 3'd3,
        SRC_SEQ  = 3'd4
    } pc_src_t;

    localparam int unsigned PC_STEP = 4;

endpackage

`default_nettype wire

// File: rtl/pc_target_calc.sv
// ============================================================================
// Module   : pc_target_calc
// Brief    : Combinational sequential, branch and jump target generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [15:0]       i_imm,
    input  logic [25:0]       i_jtarget,
    output logic [ADDR_W-1:0] o_pc_plus4,
    output logic [ADDR_W-1:0] o_br_target,
    output logic [ADDR_W-1:0] o_jump_target
);

    logic [ADDR_W-1:0] w_br_offset;

    // Word offset sign-extended and scaled to bytes; all sums wrap mod 2^ADDR_W.
    assign w_br_offset   = {{(ADDR_W-18){i_imm[15]}}, i_imm, 2'b00};
    assign o_pc_plus4    = i_pc + ADDR_W'(PC_STEP);
    assign o_br_target   = o_pc_plus4 + w_br_offset;
    assign o_jump_target = {o_pc_plus4[ADDR_W-1:28], i_jtarget, 2'b00};

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter sequencer with fetch handshake, EPC and retired
//            instruction counter. Interrupt/ISR support under PC_SEQ_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(128),
    parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(64),
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_ack,
    input  logic              branch,
    input  logic              zero,
    input  logic [15:0]       imm,
    input  logic              jump,
    input  logic [25:0]       jtarget,
    input  logic              eret,
    input  logic              int_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] epc,
    output logic              in_isr,
    output logic              int_ack,
    output logic [CNT_W-1:0]  instret
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              int_ack_q, int_ack_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic [ADDR_W-1:0] w_pc_plus4, w_br_target, w_jump_target, w_base_target;
    logic              w_accept, w_take_int;
    pc_src_t           w_base_src, w_src;

    pc_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target_calc (
        .i_pc          (pc_q),
        .i_imm         (imm),
        .i_jtarget     (jtarget),
        .o_pc_plus4    (w_pc_plus4),
        .o_br_target   (w_br_target),
        .o_jump_target (w_jump_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_VEC;
            epc_q     <= '0;
            int_ack_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            int_ack_q <= int_ack_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        int_ack_d  = 1'b0;
        instret_d  = instret_q;
        w_accept   = fetch_req && fetch_ack;
        w_take_int = 1'b0;

        if (jump)                 w_base_src = SRC_JUMP;
        else if (branch && zero)  w_base_src = SRC_BR;
        else                      w_base_src = SRC_SEQ;
`ifdef PC_SEQ_IRQ_EN
        if ((state_q == ISR) && eret) w_base_src = SRC_ERET;
        w_take_int = (state_q == RUN) && int_req;
`endif
        w_src = w_take_int ? SRC_INT : w_base_src;

        // The would-be target is needed even when an interrupt wins, as the EPC.
        case (w_base_src)
            SRC_ERET: w_base_target = epc_q;
            SRC_JUMP: w_base_target = w_jump_target;
            SRC_BR:   w_base_target = w_br_target;
            default:  w_base_target = w_pc_plus4;
        endcase

        case (state_q)
            IDLE: state_d = RUN;
            default: begin
                if (w_accept) begin
                    instret_d = instret_q + CNT_W'(1);
                    case (w_src)
                        SRC_INT: begin
                            pc_d      = INT_VEC;
                            epc_d     = w_base_target;
                            state_d   = ISR;
                            int_ack_d = 1'b1;
                        end
                        SRC_ERET: begin
                            pc_d    = w_base_target;
                            state_d = RUN;
                        end
                        default: pc_d = w_base_target;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        fetch_req = (state_q != IDLE);
        pc        = pc_q;
        pc_plus4  = w_pc_plus4;
        instret   = instret_q;
`ifdef PC_SEQ_IRQ_EN
        in_isr    = (state_q == ISR);
        epc       = epc_q;
        int_ack   = int_ack_q;
`else
        in_isr    = 1'b0;
        epc       = '0;
        int_ack   = 1'b0;
`endif
    end

`ifndef PC_SEQ_IRQ_EN
    logic unused_irq;
    assign unused_irq = ^{int_req, eret, epc_q, int_ack_q};
`endif

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle core, the successor to the fixed-width PC/next-PC logic that drives the fetch stage. It holds the architectural PC and a fetch request toward instruction memory, and advances only on an accepted fetch handshake. It selects the next PC from interrupt entry, exception return, jump, taken branch or sequential PC+4. It also keeps the saved return address (EPC) and a retired-instruction counter.

## Interface
- ADDR_W, 32: PC width in bits. Must be ≥ 30.
- RESET_VEC, 32'd128: PC value loaded at reset.
- INT_VEC, 32'd64: interrupt entry point.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_ack  in  1  instruction memory accepted the current fetch.
- branch  in  1  decoded branch for the instruction at pc.
- zero  in  1  ALU zero flag for that instruction.
- imm  in  16  branch offset, in words, signed.
- jump  in  1  decoded jump.
- jtarget  in  26  jump target field.
- eret  in  1  decoded exception return.
- int_req  in  1  level-sensitive interrupt request.
- pc  out  ADDR_W  current fetch address.
- pc_plus4  out  ADDR_W  pc + 4 (combinational).
- fetch_req  out  1  fetch valid.
- epc  out  ADDR_W  saved return address.
- in_isr  out  1  an interrupt is being serviced.
- int_ack  out  1  one-cycle pulse when an interrupt is taken.
- instret  out  CNT_W  count of accepted fetches.

## Operation
- States:
  - IDLE: entered on reset; fetch_req = 0. Moves to RUN on the first clock after reset is released.
  - RUN: fetch_req = 1; normal execution.
  - ISR: fetch_req = 1; in_isr = 1.
- Accept is defined as fetch_req && fetch_ack. With no accept, pc, epc, state and instret hold, and no interrupt is taken.
- Next-PC candidates, in priority order (highest first), evaluated only on accept:
  1. Interrupt (state RUN && int_req): pc ← INT_VEC; epc ← the target the remaining priorities would have chosen; state → ISR; int_ack = 1 for one cycle.
  2. eret in ISR: pc ← epc; state → RUN.
  3. jump: pc ← {pc_plus4[ADDR_W-1:28], jtarget, 2'b00}.
  4. branch && zero: pc ← pc_plus4 + (sign-extended imm << 2).
  5. Otherwise: pc ← pc_plus4.
- eret in RUN is treated as a no-op: pc ← pc_plus4.
- int_req while in ISR is ignored. Because the request is level-sensitive, it is taken on the first accept after the return to RUN if still asserted.
- All address arithmetic is modulo 2^ADDR_W. The PC at 2^ADDR_W−4 wraps to 0.
- The low two bits of pc are always 0.
- instret increments by 1 on every accept and wraps at 2^CNT_W.

## Timing
- Reset values: pc = RESET_VEC, epc = 0, in_isr = 0, int_ack = 0, fetch_req = 0, instret = 0, state = IDLE.
- rst takes effect immediately and asynchronously, including in the middle of a stall or in ISR. Any pending interrupt is dropped.
- Next PC is combinational from the decode inputs in the accept cycle and is registered on that edge. Latency from accept to new pc is 1 clock.
- int_ack is registered: high in the cycle after the accepting edge that took the interrupt.
- in_isr rises with the same edge that loads INT_VEC and falls with the edge that loads epc.
- fetch_req goes high one cycle after reset release and stays high until the next reset.

## Configuration
- Macro PC_SEQ_IRQ_EN.
- Defined: interrupt entry, ISR state, eret and epc behave as described above.
- Undefined: int_req and eret are ignored; the ISR state does not exist; epc, in_isr and int_ack are tied to 0; the priority reduces to jump > branch > sequential.

## Structure
- Shared package pc_seq_pkg holds:
  - the state enum {IDLE, RUN, ISR};
  - the next-PC source enum {SRC_INT, SRC_ERET, SRC_JUMP, SRC_BR, SRC_SEQ};
  - the constant PC_STEP = 4.
- One sub-module, pc_target_calc, is combinational. It produces pc_plus4 and the branch and jump targets from pc, imm and jtarget.
- Priority select, state register, epc and counter live in pc_sequencer.

## Test plan
- Reset release with fetch_ack = 1 → IDLE for 1 cycle; pc 128, 132, 136 on the following accepts; instret = 2 after two accepts.
- pc = 0x100, branch = 1, zero = 1, imm = 16'hFFFE → pc = 0x0FC. With zero = 0 → pc = 0x104.
- fetch_ack = 0 for 3 cycles with int_req = 1 → pc, instret and state unchanged. On ack → pc = 64, int_ack pulses once, epc = old pc+4.
- Interrupt coincident with jump, jtarget = 26'h40 at pc = 0x200 → pc = 64; epc = 0x100; then eret → pc = 0x100, in_isr = 0.
- pc = 0xFFFF_FFFC sequential → pc = 0. Assert rst mid-ISR → pc = 128, in_isr = 0, epc = 0 immediately.
- With PC_SEQ_IRQ_EN undefined: int_req = 1 and eret = 1 → sequential pc+4; int_ack and epc remain 0.
